// File: rtl/mem_access_unit_pkg.sv
// Shared LC-3b types plus the MEM-stage access FSM states and byte-lane masks.
package mem_access_unit_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned REG_W  = 3;
    localparam int unsigned BE_W   = 2;

    typedef logic [WORD_W-1:0] lc3b_word;
    typedef logic [REG_W-1:0]  lc3b_reg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PTR_RD   = 2'd1,
        DATA_ACC = 2'd2
    } mem_state_t;

    localparam logic [BE_W-1:0] BE_WORD = 2'b11;
    localparam logic [BE_W-1:0] BE_LO   = 2'b01;
    localparam logic [BE_W-1:0] BE_HI   = 2'b10;

endpackage : mem_access_unit_pkg

// File: rtl/mem_access_unit_byte_lane_formatter.sv
// Combinational lane steering: byte-enable, replicated store byte and
// zero-extended load byte selected by the address LSB.
module byte_lane_formatter
    import mem_access_unit_pkg::*;
(
    input  logic             i_addr_lsb,
    input  logic             i_byte,
    input  lc3b_word         i_store_data,
    input  lc3b_word         i_load_raw,
    output logic [BE_W-1:0]  o_byte_enable,
    output lc3b_word         o_wdata,
    output lc3b_word         o_load_data
);

    always_comb begin
        o_byte_enable = BE_WORD;
        o_wdata       = i_store_data;
        o_load_data   = i_load_raw;
        if (i_byte) begin
            o_byte_enable = i_addr_lsb ? BE_HI : BE_LO;
            o_wdata       = {i_store_data[7:0], i_store_data[7:0]};
            o_load_data   = i_addr_lsb ? {8'h00, i_load_raw[15:8]}
                                       : {8'h00, i_load_raw[7:0]};
        end
    end

endmodule : byte_lane_formatter

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access FSM (IDLE/PTR_RD/DATA_ACC) with LDI/STI pointer fetch.
// Optional MEM_ALIGN_TRAP_EN adds mem_misaligned and suppresses odd word accesses.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid,
    input  lc3b_word         mem_address,
    input  lc3b_word         mem_alu_out,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             mem_byte,
    input  logic             mem_indirect,
    output lc3b_word         dmem_address,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic [BE_W-1:0]  dmem_byte_enable,
    output lc3b_word         dmem_wdata,
    input  lc3b_word         dmem_rdata,
    input  logic             dmem_resp,
    output lc3b_word         mem_rdata,
    output logic             mem_stall
`ifdef MEM_ALIGN_TRAP_EN
    ,
    output logic             mem_misaligned
`endif
);

    mem_state_t      r_state;
    mem_state_t      w_state_nxt;
    lc3b_word        r_ptr;
    lc3b_word        w_ptr_nxt;
    lc3b_word        r_rdata;
    lc3b_word        w_rdata_nxt;

    logic            w_access;
    lc3b_word        w_eff_addr;
    logic            w_align_fault;
    logic [BE_W-1:0] w_fmt_be;
    lc3b_word        w_fmt_wdata;
    lc3b_word        w_fmt_load;

    assign w_access   = mem_valid & (mem_read | mem_write);
    assign w_eff_addr = mem_indirect ? r_ptr : mem_address;

`ifdef MEM_ALIGN_TRAP_EN
    assign w_align_fault = ~mem_byte & w_eff_addr[0];
`else
    assign w_align_fault = 1'b0;
`endif

    byte_lane_formatter u_fmt (
        .i_addr_lsb    (w_eff_addr[0]),
        .i_byte        (mem_byte),
        .i_store_data  (mem_alu_out),
        .i_load_raw    (dmem_rdata),
        .o_byte_enable (w_fmt_be),
        .o_wdata       (w_fmt_wdata),
        .o_load_data   (w_fmt_load)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_rdata <= w_rdata_nxt;
        end
    end

    // Next state, request port and stall; a write wins when both op bits are set.
    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_rdata_nxt      = r_rdata;
        dmem_address     = '0;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_byte_enable = '0;
        dmem_wdata       = '0;
        mem_rdata        = r_rdata;
        mem_stall        = 1'b0;
`ifdef MEM_ALIGN_TRAP_EN
        mem_misaligned   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    if (mem_indirect) begin
                        mem_stall   = 1'b1;
                        w_state_nxt = PTR_RD;
                    end else if (w_align_fault) begin
                        mem_rdata   = '0;
                        w_rdata_nxt = '0;
`ifdef MEM_ALIGN_TRAP_EN
                        mem_misaligned = 1'b1;
`endif
                    end else begin
                        mem_stall   = 1'b1;
                        w_state_nxt = DATA_ACC;
                    end
                end
            end
            PTR_RD: begin
                mem_stall        = 1'b1;
                dmem_read        = 1'b1;
                dmem_address     = {mem_address[15:1], 1'b0};
                dmem_byte_enable = BE_WORD;
                if (dmem_resp) begin
                    w_ptr_nxt   = dmem_rdata;
                    w_state_nxt = DATA_ACC;
                end
            end
            DATA_ACC: begin
                if (w_align_fault) begin
                    mem_rdata   = '0;
                    w_rdata_nxt = '0;
                    w_state_nxt = IDLE;
`ifdef MEM_ALIGN_TRAP_EN
                    mem_misaligned = 1'b1;
`endif
                end else begin
                    dmem_address     = mem_byte ? w_eff_addr : {w_eff_addr[15:1], 1'b0};
                    dmem_byte_enable = w_fmt_be;
                    dmem_wdata       = w_fmt_wdata;
                    dmem_write       = mem_write;
                    dmem_read        = ~mem_write;
                    mem_stall        = 1'b1;
                    if (dmem_resp) begin
                        mem_stall   = 1'b0;
                        mem_rdata   = w_fmt_load;
                        w_rdata_nxt = w_fmt_load;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule : mem_access_unit

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register in the pipelined LC-3b core.
- Takes the latched address, store data and decoded memory-control bits, and drives the data-memory port with a read/write/resp handshake.
- Handles byte lanes and two-access indirect ops (LDI/STI).
- Returns formatted load data toward MEM/WB and drives the pipeline-wide stall.

Parameters:
- None. All widths are fixed by lc3b_types: lc3b_word = 16 bits, lc3b_reg = 3 bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_valid  in  1  MEM-stage instruction valid
- mem_address  in  16  effective address from EX
- mem_alu_out  in  16  store data (SR value)
- mem_read  in  1  load op (LDR/LDB/LDI)
- mem_write  in  1  store op (STR/STB/STI)
- mem_byte  in  1  byte-sized access
- mem_indirect  in  1  LDI/STI: first read fetches the pointer
- dmem_address  out  16  data-memory address
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_byte_enable  out  2  lane mask
- dmem_wdata  out  16  write data
- dmem_rdata  in  16  read data
- dmem_resp  in  1  access complete
- mem_rdata  out  16  formatted load data to MEM/WB
- mem_stall  out  1  hold all pipeline registers (load = !mem_stall)

Behaviour:
- FSM states: IDLE, PTR_RD, DATA_ACC.
- Reset (synchronous, active-high) takes effect at the next clk edge:
  - state = IDLE, ptr_reg = 0, rdata_reg = 0.
  - Outputs after reset: dmem_read = 0, dmem_write = 0, dmem_address = 0, dmem_wdata = 0, dmem_byte_enable = 0, mem_stall = 0, mem_rdata = 0.
  - A reset asserted mid-access abandons the access; requests drop the cycle after the reset edge.
- Access definition: access = mem_valid & (mem_read | mem_write). If both mem_read and mem_write are set, the op is treated as a write.
- IDLE:
  - No access: mem_stall = 0, no request.
  - Access: mem_stall = 1, no request. Next state is PTR_RD if mem_indirect, else DATA_ACC.
- PTR_RD:
  - dmem_read = 1, address = {mem_address[15:1], 0}, byte_enable = 11.
  - On dmem_resp: ptr_reg <= dmem_rdata; go to DATA_ACC.
- DATA_ACC:
  - Effective address A = mem_indirect ? ptr_reg : mem_address.
  - Drives dmem_read or dmem_write per op.
  - Requests stay stable until dmem_resp.
- Word access:
  - dmem_address = {A[15:1], 0}, byte_enable = 11.
  - dmem_wdata = mem_alu_out.
  - Load data = dmem_rdata.
- Byte access:
  - dmem_address = A.
  - byte_enable = A[0] ? 10 : 01.
  - dmem_wdata = {mem_alu_out[7:0], mem_alu_out[7:0]}.
  - Load data = zero-extended dmem_rdata[15:8] if A[0] = 1, else dmem_rdata[7:0].
- Stall and completion:
  - mem_stall = 1 in PTR_RD, and in DATA_ACC until dmem_resp.
  - In the dmem_resp cycle of DATA_ACC: mem_stall = 0, mem_rdata = formatted data (combinational passthrough), rdata_reg <= formatted data, next state = IDLE.
  - Minimum latency: non-indirect = 2 cycles (IDLE + 1-cycle resp); indirect = 3 cycles.
- mem_rdata otherwise = rdata_reg.
- dmem_resp outside PTR_RD/DATA_ACC is ignored.
- mem_valid = 0 never stalls.

Optional Feature:
- Macro: MEM_ALIGN_TRAP_EN.
- Defined:
  - Adds output mem_misaligned (1 bit).
  - A word access with A[0] = 1 issues no request, completes with mem_rdata = 0 and pulses mem_misaligned for one cycle.
  - A direct access completes in its IDLE cycle (mem_stall = 0).
  - An indirect access whose pointer is odd completes in DATA_ACC without a request.
- Undefined: the port is absent and A[0] is silently forced to 0 for word accesses.

Decomposition:
- Add to lc3b_types:
  - enum mem_state_t {IDLE, PTR_RD, DATA_ACC}.
  - Constants BE_WORD = 2'b11, BE_LO = 2'b01, BE_HI = 2'b10.
- Sub-module byte_lane_formatter (combinational): takes A[0], mem_byte, store data and dmem_rdata; produces byte_enable, wdata and load data.
- The FSM lives in mem_access_unit.

Test Plan:
- LDR, A = x3004, resp after 2 wait cycles, rdata = xBEEF -> dmem_read held 3 cycles at x3004 with BE = 11; mem_rdata = xBEEF in the resp cycle; stall = 1 for 3 cycles then 0.
- STB, A = x3005, SR = x12A7 -> dmem_write, address x3005, BE = 10, wdata = xA7A7; stall releases on resp.
- LDB, A = x3005, rdata = x80FF -> mem_rdata = x0080.
- LDI, A = x4000, pointer read returns x5002, data read returns x1234 -> reads at x4000 then x5002; mem_rdata = x1234.
- STI with reset asserted in PTR_RD -> state IDLE next cycle; dmem_read and dmem_write = 0; mem_rdata = 0.
- mem_valid = 0 with mem_read = 1 -> no request and mem_stall = 0. With MEM_ALIGN_TRAP_EN: LDR at x3001 -> no request, mem_misaligned = 1, mem_rdata = 0.
